button_event_queue: RTL and testbench

Downstream consumer of the `user_io` button bus. It debounces the 8 raw button levels that `user_io` refreshes from the I2C port expander, and holds the current debounced levels. Each debounced level change is turned into an event word and queued in an 8-deep FIFO. Host-side logic drains the FIFO through a valid/ready handshake.

---
 rtl/button_event_queue.sv | 178 +++++++++++++++++
 tb/tb_button_event_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// ---------------------------------------------------------------------------
// button_event_queue
//
// Debounces the eight raw button levels delivered by user_io and keeps the
// debounced levels. Every accepted level change becomes a 4-bit event word
// {new_level, index[2:0]}. Events go into an 8-deep show-ahead FIFO, and the
// host drains that FIFO through a valid/ready handshake.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a raw level must differ from the
//                     stable level before it is accepted (2 .. 2^24)
//   IDLE_LEVEL      : stable levels loaded at reset
//
// Ports
//   i_clk            in   system clock
//   i_reset          in   synchronous, active-high reset
//   i_button[7:0]    in   raw button levels, already in the i_clk domain
//   o_button_stable  out  debounced button levels
//   o_event_valid    out  FIFO head holds an event
//   o_event_data     out  FIFO head event {new_level, index[2:0]}
//   i_event_ready    in   consumer pops the head when valid && ready
//   o_fifo_count     out  number of queued events, 0..8
//   o_overflow       out  sticky, set when an event is dropped
//   i_clear_overflow in   clears o_overflow (a drop on the same edge wins)
// ---------------------------------------------------------------------------
module button_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter logic [7:0]  IDLE_LEVEL      = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_button,
  output logic [7:0] o_button_stable,
  output logic       o_event_valid,
  output logic [3:0] o_event_data,
  input  logic       i_event_ready,
  output logic [3:0] o_fifo_count,
  output logic       o_overflow,
  input  logic       i_clear_overflow
);

  localparam int unsigned   CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Debounce state
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       stable_q, stable_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       settle;

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    settle   = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_button[i] == stable_q[i]) begin
        // Level agrees with the stable value: any glitch restarts the count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = i_button[i];
        cnt_d[i]    = '0;
        settle[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arbiter: lowest pending index is serviced, one event per cycle
  // -------------------------------------------------------------------------
  logic       grant_any;
  logic [2:0] grant_idx;
  logic [7:0] grant_mask;
  logic [3:0] push_data;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = 3'd0;
    // Scan downwards so the last hit, i.e. the lowest index, wins.
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_any = 1'b1;
        grant_idx = 3'(i);
      end
    end
    grant_mask = grant_any ? (8'b1 << grant_idx) : 8'b0;
    push_data  = {stable_q[grant_idx], grant_idx};
  end

  // A bit that settles on the same edge it is serviced stays pending.
  assign pend_d = (pend_q & ~grant_mask) | settle;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic [3:0] mem_q [8];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       pop, push_ok, drop;

  always_comb begin
    pop     = (count_q != 4'd0) && i_event_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    push_ok = grant_any && ((count_q != 4'd8) || pop);
    drop    = grant_any && !push_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + 3'd1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 3'd1 : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stable_q   <= IDLE_LEVEL;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q   <= stable_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and the head output is forced to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (registers or direct decodes of registers only)
  // -------------------------------------------------------------------------
  assign o_button_stable = stable_q;
  assign o_event_valid   = (count_q != 4'd0);
  assign o_event_data    = o_event_valid ? mem_q[rd_ptr_q] : 4'h0;
  assign o_fifo_count    = count_q;
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// ---------------------------------------------------------------------------
// tb_button_event_queue
//
// Directed bench for button_event_queue with DEBOUNCE_CYCLES = 16. Inputs are
// driven and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge in between. Expected values are hand-derived event words.
// ---------------------------------------------------------------------------
module tb_button_event_queue;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_button;
  logic [7:0] o_button_stable;
  logic       o_event_valid;
  logic [3:0] o_event_data;
  logic       i_event_ready;
  logic [3:0] o_fifo_count;
  logic       o_overflow;
  logic       i_clear_overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_event_queue #(
    .DEBOUNCE_CYCLES(16),
    .IDLE_LEVEL     (8'h00)
  ) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_button        (i_button),
    .o_button_stable (o_button_stable),
    .o_event_valid   (o_event_valid),
    .o_event_data    (o_event_data),
    .i_event_ready   (i_event_ready),
    .o_fifo_count    (o_fifo_count),
    .o_overflow      (o_overflow),
    .i_clear_overflow(i_clear_overflow)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [3:0] exp_seq [4] = '{4'h9, 4'hB, 4'hC, 4'hE};
    i_reset = 1'b1; i_button = 8'h5A; i_event_ready = 1'b0; i_clear_overflow = 1'b0;
    wait_cycles(3);
    n_cmp++; if (o_button_stable !== 8'h00) begin n_err++; $display("FAIL reset_stable: got %h want 00", o_button_stable); end
    n_cmp++; if (o_fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_fifo_count); end
    n_cmp++; if (o_event_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_event_valid); end
    n_cmp++; if (o_event_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", o_event_data); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    i_reset = 1'b0; i_event_ready = 1'b1;
    wait_cycles(15);
    n_cmp++; if (o_button_stable !== 8'h00) begin n_err++; $display("FAIL reset_early_stable: got %h want 00", o_button_stable); end
    wait_cycles(1);
    n_cmp++; if (o_button_stable !== 8'h5A) begin n_err++; $display("FAIL reset_settle_stable: got %h want 5a", o_button_stable); end
    n_cmp++; if (o_event_valid !== 1'b0) begin n_err++; $display("FAIL reset_settle_valid: got %b want 0", o_event_valid); end
    // With ready held high, each event is the head for exactly one cycle.
    for (int k = 0; k < 4; k++) begin
      wait_cycles(1);
      n_cmp++; if (o_event_valid !== 1'b1 || o_event_data !== exp_seq[k] || o_fifo_count !== 4'd1) begin
        n_err++; $display("FAIL reset_event%0d: got v=%b d=%h c=%0d want v=1 d=%h c=1", k, o_event_valid, o_event_data, o_fifo_count, exp_seq[k]);
      end
    end
    wait_cycles(1);
    n_cmp++; if (o_event_valid !== 1'b0 || o_fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_drained: got v=%b c=%0d want v=0 c=0", o_event_valid, o_fifo_count); end
    i_event_ready = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_glitch();
    i_button = 8'h5E;            // bit 2 high for 15 cycles only
    wait_cycles(15);
    i_button = 8'h5A;
    wait_cycles(20);
    n_cmp++; if (o_button_stable !== 8'h5A) begin n_err++; $display("FAIL glitch_stable: got %h want 5a", o_button_stable); end
    n_cmp++; if (o_event_valid !== 1'b0) begin n_err++; $display("FAIL glitch_no_event: got %b want 0", o_event_valid); end
    i_button = 8'h5E;            // now held long enough
    wait_cycles(16);
    n_cmp++; if (o_button_stable !== 8'h5E || o_event_valid !== 1'b0) begin n_err++; $display("FAIL glitch_hold16: got s=%h v=%b want s=5e v=0", o_button_stable, o_event_valid); end
    wait_cycles(1);
    n_cmp++; if (o_event_valid !== 1'b1 || o_event_data !== 4'hA) begin n_err++; $display("FAIL glitch_hold17: got v=%b d=%h want v=1 d=a", o_event_valid, o_event_data); end
    i_event_ready = 1'b1;
    wait_cycles(1);
    i_event_ready = 1'b0;
    n_cmp++; if (o_fifo_count !== 4'd0) begin n_err++; $display("FAIL glitch_drain: got %0d want 0", o_fifo_count); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_simultaneous();
    i_reset = 1'b1; i_button = 8'h00;
    wait_cycles(2);
    i_reset = 1'b0;
    i_button = 8'h81;
    wait_cycles(16);
    n_cmp++; if (o_button_stable !== 8'h81 || o_fifo_count !== 4'd0) begin n_err++; $display("FAIL simul_settle: got s=%h c=%0d want s=81 c=0", o_button_stable, o_fifo_count); end
    wait_cycles(1);
    n_cmp++; if (o_fifo_count !== 4'd1 || o_event_data !== 4'h8) begin n_err++; $display("FAIL simul_first: got c=%0d d=%h want c=1 d=8", o_fifo_count, o_event_data); end
    wait_cycles(1);
    n_cmp++; if (o_fifo_count !== 4'd2 || o_event_data !== 4'h8) begin n_err++; $display("FAIL simul_second: got c=%0d d=%h want c=2 d=8", o_fifo_count, o_event_data); end
    i_event_ready = 1'b1;
    wait_cycles(1);
    n_cmp++; if (o_fifo_count !== 4'd1 || o_event_data !== 4'hF) begin n_err++; $display("FAIL simul_pop: got c=%0d d=%h want c=1 d=f", o_fifo_count, o_event_data); end
    wait_cycles(1);
    i_event_ready = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_handshake();
    logic [3:0] exp_seq [3] = '{4'h0, 4'h9, 4'hA};
    i_button = 8'h86;            // bit0 falls, bits 1 and 2 rise
    wait_cycles(19);
    n_cmp++; if (o_fifo_count !== 4'd3) begin n_err++; $display("FAIL hs_queued: got %0d want 3", o_fifo_count); end
    i_event_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (o_event_valid !== 1'b1 || o_event_data !== exp_seq[k] || o_fifo_count !== 4'(3 - k)) begin
        n_err++; $display("FAIL hs_pop%0d: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", k, o_event_valid, o_event_data, o_fifo_count, exp_seq[k], 3 - k);
      end
      wait_cycles(1);
    end
    n_cmp++; if (o_event_valid !== 1'b0 || o_fifo_count !== 4'd0) begin n_err++; $display("FAIL hs_empty: got v=%b c=%0d want v=0 c=0", o_event_valid, o_fifo_count); end
    i_event_ready = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overflow();
    logic [3:0] exp_seq [8] = '{4'h1, 4'h2, 4'hB, 4'hC, 4'hD, 4'hE, 4'h7, 4'h8};
    i_button = 8'h79;            // all eight bits flip: eight events
    wait_cycles(24);
    n_cmp++; if (o_fifo_count !== 4'd8 || o_overflow !== 1'b0 || o_event_data !== 4'h8) begin
      n_err++; $display("FAIL ovf_full: got c=%0d o=%b d=%h want c=8 o=0 d=8", o_fifo_count, o_overflow, o_event_data);
    end
    i_button = 8'h78;            // ninth event (4'h0) must be dropped
    wait_cycles(17);
    n_cmp++; if (o_fifo_count !== 4'd8 || o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop: got c=%0d o=%b want c=8 o=1", o_fifo_count, o_overflow); end
    i_clear_overflow = 1'b1;
    wait_cycles(1);
    i_clear_overflow = 1'b0;
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", o_overflow); end
    i_button = 8'h79;            // event 4'h8 arrives while full, with a pop
    wait_cycles(16);
    i_event_ready = 1'b1;
    wait_cycles(1);
    i_event_ready = 1'b0;
    n_cmp++; if (o_fifo_count !== 4'd8 || o_overflow !== 1'b0 || o_event_data !== 4'h1) begin
      n_err++; $display("FAIL ovf_push_pop: got c=%0d o=%b d=%h want c=8 o=0 d=1", o_fifo_count, o_overflow, o_event_data);
    end
    i_event_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (o_event_data !== exp_seq[k]) begin n_err++; $display("FAIL ovf_order%0d: got %h want %h", k, o_event_data, exp_seq[k]); end
      wait_cycles(1);
    end
    i_event_ready = 1'b0;
    n_cmp++; if (o_fifo_count !== 4'd0 || o_event_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got c=%0d v=%b want c=0 v=0", o_fifo_count, o_event_valid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    logic [7:0] exp_stable = 8'h79;
    logic [3:0] exp_ev;
    int         j;
    for (int k = 0; k < 20; k++) begin
      j = k % 8;
      exp_stable[j] = ~exp_stable[j];
      exp_ev = {exp_stable[j], 3'(j)};
      i_button = exp_stable;
      wait_cycles(17);
      n_cmp++; if (o_event_valid !== 1'b1 || o_event_data !== exp_ev) begin
        n_err++; $display("FAIL wrap_ev%0d: got v=%b d=%h want v=1 d=%h", k, o_event_valid, o_event_data, exp_ev);
      end
      i_event_ready = 1'b1;
      wait_cycles(1);
      i_event_ready = 1'b0;
    end
    n_cmp++; if (o_fifo_count !== 4'd0 || o_button_stable !== exp_stable) begin
      n_err++; $display("FAIL wrap_end: got c=%0d s=%h want c=0 s=%h", o_fifo_count, o_button_stable, exp_stable);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_midop();
    i_reset = 1'b1; i_button = 8'h00;
    wait_cycles(2);
    i_reset = 1'b0;
    wait_cycles(1);
    i_button = 8'h1F;            // five events queued
    wait_cycles(21);
    n_cmp++; if (o_fifo_count !== 4'd5) begin n_err++; $display("FAIL mid_count5: got %0d want 5", o_fifo_count); end
    i_button = 8'h9F;            // bit 7 half-way through its debounce
    wait_cycles(8);
    i_reset = 1'b1; i_button = 8'h80;
    wait_cycles(1);
    i_reset = 1'b0;
    n_cmp++; if (o_fifo_count !== 4'd0 || o_event_valid !== 1'b0 || o_button_stable !== 8'h00) begin
      n_err++; $display("FAIL mid_reset: got c=%0d v=%b s=%h want c=0 v=0 s=00", o_fifo_count, o_event_valid, o_button_stable);
    end
    wait_cycles(15);             // bit 7 must need a full fresh count
    n_cmp++; if (o_event_valid !== 1'b0 || o_button_stable !== 8'h00) begin
      n_err++; $display("FAIL mid_no_early: got v=%b s=%h want v=0 s=00", o_event_valid, o_button_stable);
    end
    wait_cycles(2);
    n_cmp++; if (o_event_valid !== 1'b1 || o_event_data !== 4'hF || o_fifo_count !== 4'd1) begin
      n_err++; $display("FAIL mid_fresh: got v=%b d=%h c=%0d want v=1 d=f c=1", o_event_valid, o_event_data, o_fifo_count);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_glitch();
    test_simultaneous();
    test_handshake();
    test_overflow();
    test_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
